// File: rtl/dot_acc_sequencer.sv
// Dot-product sequencer driving an external End_adder accumulation stage.
// Optional initial bias: define DOT_SEQ_BIAS_EN to add the bias port.
module dot_acc_sequencer #(
   parameter int unsigned DWIDTH = 32,
   parameter int unsigned LEN_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
`ifdef DOT_SEQ_BIAS_EN
   input  logic [DWIDTH-1:0] bias,
`endif
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   output logic              busy,
   input  logic [DWIDTH-1:0] prod_data,
   input  logic              prod_valid,
   output logic              prod_ready,
   output logic [DWIDTH-1:0] add_sum,
   output logic [DWIDTH-1:0] add_prod,
   output logic              add_valid,
   input  logic [DWIDTH-1:0] add_result,
   input  logic              add_done,
   output logic [DWIDTH-1:0] res_data,
   output logic              res_valid,
   input  logic              res_ready
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_FETCH  = 2'd1;
   localparam logic [1:0] S_ADD    = 2'd2;
   localparam logic [1:0] S_RESULT = 2'd3;

   logic [1:0]        state, state_nxt;
   logic [DWIDTH-1:0] acc, acc_nxt;
   logic [DWIDTH-1:0] op, op_nxt;
   logic [LEN_W-1:0]  cnt, cnt_nxt;
   logic [DWIDTH-1:0] acc_init;

`ifdef DOT_SEQ_BIAS_EN
   assign acc_init = bias;
`else
   assign acc_init = '0;
`endif

   // Next-state and datapath update
   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      op_nxt    = op;
      cnt_nxt   = cnt;
      case (state)
         S_IDLE: begin
            if (start) begin
               acc_nxt   = acc_init;
               cnt_nxt   = len;
               state_nxt = (len == '0) ? S_RESULT : S_FETCH;
            end
         end
         S_FETCH: begin
            if (prod_valid) begin
               op_nxt    = prod_data;
               state_nxt = S_ADD;
            end
         end
         S_ADD: begin
            if (add_done) begin
               acc_nxt   = add_result;
               cnt_nxt   = cnt - LEN_W'(1);
               state_nxt = (cnt == LEN_W'(1)) ? S_RESULT : S_FETCH;
            end
         end
         S_RESULT: begin
            if (res_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // State register; outputs are registered decodes of the state being entered
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         acc        <= '0;
         op         <= '0;
         cnt        <= '0;
         busy       <= 1'b0;
         prod_ready <= 1'b0;
         add_valid  <= 1'b0;
         add_sum    <= '0;
         add_prod   <= '0;
         res_valid  <= 1'b0;
         res_data   <= '0;
      end else begin
         state      <= state_nxt;
         acc        <= acc_nxt;
         op         <= op_nxt;
         cnt        <= cnt_nxt;
         busy       <= (state_nxt != S_IDLE);
         prod_ready <= (state_nxt == S_FETCH);
         add_valid  <= (state_nxt == S_ADD);
         add_sum    <= (state_nxt == S_ADD) ? acc_nxt : '0;
         add_prod   <= (state_nxt == S_ADD) ? op_nxt : '0;
         res_valid  <= (state_nxt == S_RESULT);
         res_data   <= (state_nxt == S_RESULT) ? acc_nxt : '0;
      end
   end

endmodule

// File: tb/tb_dot_acc_sequencer.sv
// Directed bench for dot_acc_sequencer with a two-cycle adder model.
module tb_dot_acc_sequencer;

   localparam int unsigned DW = 32;
   localparam int unsigned LW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [LW-1:0] len;
   logic          busy;
   logic [DW-1:0] prod_data;
   logic          prod_valid;
   logic          prod_ready;
   logic [DW-1:0] add_sum, add_prod, add_result;
   logic          add_valid, add_done;
   logic [DW-1:0] res_data;
   logic          res_valid;
   logic          res_ready;
`ifdef DOT_SEQ_BIAS_EN
   logic [DW-1:0] bias;
`endif

   int n_checks = 0;
   int n_err    = 0;
   logic [DW-1:0] prods [0:3];

   always #5 clk = ~clk;

   dot_acc_sequencer #(.DWIDTH(DW), .LEN_W(LW)) dut (
      .clk(clk), .rst_n(rst_n),
`ifdef DOT_SEQ_BIAS_EN
      .bias(bias),
`endif
      .start(start), .len(len), .busy(busy),
      .prod_data(prod_data), .prod_valid(prod_valid), .prod_ready(prod_ready),
      .add_sum(add_sum), .add_prod(add_prod), .add_valid(add_valid),
      .add_result(add_result), .add_done(add_done),
      .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready)
   );

   // Adder model: result and done appear in the second cycle of add_valid
   logic s1;
   always_ff @(posedge clk) begin
      if (!rst_n) s1 <= 1'b0;
      else        s1 <= add_valid && !s1;
   end
   assign add_done   = add_valid && s1;
   assign add_result = add_sum + add_prod;

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"},       DW'(busy), 0);
      chk({tag, "_prod_ready"}, DW'(prod_ready), 0);
      chk({tag, "_add_valid"},  DW'(add_valid), 0);
      chk({tag, "_add_sum"},    add_sum, 0);
      chk({tag, "_add_prod"},   add_prod, 0);
      chk({tag, "_res_valid"},  DW'(res_valid), 0);
      chk({tag, "_res_data"},   res_data, 0);
   endtask

   // One complete dot product from prods[0..n-1]; exp_lat < 0 skips the latency check
   task automatic run(input string tag, input int n, input int gap, input int hold,
                      input bit pulse, input logic [DW-1:0] exp_res, input int exp_lat);
      int idx = 0, stall = 0, lat = 0, adds = 0, busy_lo = 0;
      bit accept;
      logic [DW-1:0] held;
      len        = LW'(n);
      start      = 1'b1;
      prod_data  = prods[0];
      prod_valid = (n > 0);
      tick;
      start = 1'b0;
      lat   = 1;
      for (int c = 0; c < 300 && !res_valid; c++) begin
         accept = prod_ready && prod_valid;
         if (add_valid) adds++;
         if (!busy) busy_lo++;
         if (pulse && lat == 2) begin start = 1'b1; len = '0; end
         else start = 1'b0;
         tick;
         lat++;
         if (accept) begin
            idx++;
            if (idx < n) begin
               prod_data = prods[idx];
               if (gap > 0) begin prod_valid = 1'b0; stall = gap; end
            end else prod_valid = 1'b0;
         end else if (stall > 0) begin
            stall--;
            if (stall == 0) prod_valid = 1'b1;
         end
      end
      start = 1'b0;
      chk({tag, "_timeout"}, DW'(res_valid), 1);
      if (exp_lat >= 0) chk({tag, "_latency"}, DW'(lat), DW'(exp_lat));
      chk({tag, "_add_cycles"}, DW'(adds), DW'(2 * n));
      chk({tag, "_busy_low"}, DW'(busy_lo), 0);
      chk({tag, "_res_data"}, res_data, exp_res);
      held = res_data;
      for (int h = 0; h < hold; h++) begin
         tick;
         chk({tag, "_hold_valid"}, DW'(res_valid), 1);
         chk({tag, "_hold_data"}, res_data, held);
      end
      res_ready = 1'b1;
      tick;
      res_ready = 1'b0;
      chk({tag, "_post_valid"}, DW'(res_valid), 0);
      chk({tag, "_post_busy"}, DW'(busy), 0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; len = '0; prod_data = '0; prod_valid = 1'b0; res_ready = 1'b0;
`ifdef DOT_SEQ_BIAS_EN
      bias = '0;
`endif
      tick; tick;
      chk_all_zero("reset");
      rst_n = 1'b1;
      tick;

`ifdef DOT_SEQ_BIAS_EN
      bias = 32'd10;
      prods[0] = 1; prods[1] = 2;
      run("bias", 2, 0, 0, 1'b0, 32'd13, 7);
      run("bias_len0", 0, 0, 0, 1'b0, 32'd10, 1);
      bias = '0;
`endif

      prods[0] = 2; prods[1] = 3; prods[2] = 4;
      run("basic", 3, 0, 0, 1'b0, 32'd9, 10);

      run("len0", 0, 0, 0, 1'b0, 32'd0, 1);

      prods[0] = 5; prods[1] = 6;
      run("stall", 2, 4, 5, 1'b0, 32'd11, -1);

      prods[0] = 32'hFFFF_FFFF; prods[1] = 2;
      run("wrap", 2, 0, 0, 1'b0, 32'h0000_0001, 7);

      prods[0] = 1; prods[1] = 1; prods[2] = 1;
      run("busy_start", 3, 0, 0, 1'b1, 32'd3, 10);

      // Abort during the ADD of the second term
      len = 8'd2; start = 1'b1; prod_valid = 1'b1; prod_data = 32'd5;
      tick;
      start = 1'b0;
      tick;
      prod_data = 32'd6;
      tick; tick; tick;
      chk("abort_in_add", DW'(add_valid), 1);
      chk("abort_add_sum", add_sum, 32'd5);
      chk("abort_add_prod", add_prod, 32'd6);
      rst_n = 1'b0; prod_valid = 1'b0;
      tick;
      chk_all_zero("abort");
      rst_n = 1'b1;
      tick;

      prods[0] = 7;
      run("after_abort", 1, 0, 0, 1'b0, 32'd7, 4);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
